mic1_sequencer: RTL and testbench

MIC1_SEQUENCER -- requirements
Module: mic1_sequencer

---
 rtl/mic1_pkg.sv | 37 +++
 rtl/mic1_next_addr.sv | 21 ++
 rtl/mic1_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mic1_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_pkg.sv
// MIC-1 microsequencer shared definitions: state encoding, microinstruction
// field layout, ALU select presets and the halt address.
package mic1_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_MEMWAIT,
      ST_NEXT,
      ST_HALT
   } seq_state_t;

   localparam int MIR_W    = 36;
   localparam int NA_LSB   = 27;
   localparam int NA_W     = 9;
   localparam int JMPC_BIT = 26;
   localparam int JAMN_BIT = 25;
   localparam int JAMZ_BIT = 24;
   localparam int ALU_LSB  = 16;
   localparam int ALU_W    = 8;
   localparam int C_LSB    = 7;
   localparam int C_W      = 9;
   localparam int MEM_LSB  = 4;
   localparam int MEM_W    = 3;
   localparam int B_LSB    = 0;
   localparam int B_W      = 4;

   // ALU select order, msb first: SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC
   localparam logic [ALU_W-1:0] ALU_A     = 8'b00011000;
   localparam logic [ALU_W-1:0] ALU_B     = 8'b00010100;
   localparam logic [ALU_W-1:0] ALU_NOT_A = 8'b00011010;

   localparam logic [NA_W-1:0] HALT_ADDR = 9'h1FF;

endpackage

// File: rtl/mic1_next_addr.sv
// Combinational next-MPC: N/Z jams into bit 8, MBR ORed into the low byte on JMPC.
module mic1_next_addr
   import mic1_pkg::*;
(
   input  logic [NA_W-1:0] next_address,
   input  logic            jmpc,
   input  logic            jamn,
   input  logic            jamz,
   input  logic            nff,
   input  logic            zff,
   input  logic [7:0]      mbr,
   output logic [NA_W-1:0] next_mpc
);

   always_comb begin
      next_mpc      = '0;
      next_mpc[8]   = next_address[8] | (jamn & nff) | (jamz & zff);
      next_mpc[7:0] = next_address[7:0] | (jmpc ? mbr : 8'h00);
   end

endmodule

// File: rtl/mic1_sequencer.sv
// MIC-1 microsequencer: fetch / execute / write-back / memory-wait / next-address.
// Optional single-step gating of NEXT is compiled in with MIC1_SEQ_STEP_EN.
//
// state   | meaning
// IDLE    | waiting for run
// FETCH   | mpc held for ROM_LATENCY cycles, MIR loaded on the last one
// EXEC    | ALU/B selects driven from MIR
// WB      | C-bus strobes driven for one cycle, N/Z captured on exit
// MEMWAIT | memory strobes held until mem_ready
// NEXT    | next mpc computed; honours run (and step when compiled in)
// HALT    | parked at the halt address until reset
module mic1_sequencer
   import mic1_pkg::*;
#(
   parameter int unsigned      ROM_LATENCY = 1,
   parameter logic [NA_W-1:0]  RESET_MPC   = 9'h000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
`ifdef MIC1_SEQ_STEP_EN
   input  logic              step,
`endif
   output logic [NA_W-1:0]   mpc,
   input  logic [MIR_W-1:0]  mir_in,
   output logic [ALU_W-1:0]  alu_select,
   input  logic              n_in,
   input  logic              z_in,
   output logic [B_W-1:0]    b_select,
   output logic [C_W-1:0]    c_enable,
   output logic              mem_write,
   output logic              mem_read,
   output logic              mem_fetch,
   input  logic              mem_ready,
   input  logic [7:0]        mbr,
   output logic              halted,
   output logic              busy
);

   localparam logic [2:0] LAT_INIT = 3'(ROM_LATENCY - 1);

   seq_state_t         state;
   logic [MIR_W-1:0]   mir;
   logic               nff;
   logic               zff;
   logic [2:0]         lat_cnt;
   logic [NA_W-1:0]    next_mpc;
   logic               step_ok;

   logic [ALU_W-1:0]   mir_alu;
   logic [B_W-1:0]     mir_b;
   logic [C_W-1:0]     mir_c;
   logic [MEM_W-1:0]   mir_mem;

   assign mir_alu = mir[ALU_LSB +: ALU_W];
   assign mir_b   = mir[B_LSB +: B_W];
   assign mir_c   = mir[C_LSB +: C_W];
   assign mir_mem = mir[MEM_LSB +: MEM_W];

`ifdef MIC1_SEQ_STEP_EN
   assign step_ok = step;
`else
   assign step_ok = 1'b1;
`endif

   mic1_next_addr u_next_addr (
      .next_address (mir[NA_LSB +: NA_W]),
      .jmpc         (mir[JMPC_BIT]),
      .jamn         (mir[JAMN_BIT]),
      .jamz         (mir[JAMZ_BIT]),
      .nff          (nff),
      .zff          (zff),
      .mbr          (mbr),
      .next_mpc     (next_mpc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mpc        <= RESET_MPC;
         mir        <= '0;
         nff        <= 1'b0;
         zff        <= 1'b0;
         lat_cnt    <= '0;
         alu_select <= '0;
         b_select   <= '0;
         c_enable   <= '0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
         mem_fetch  <= 1'b0;
         halted     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (run) begin
                  lat_cnt <= LAT_INIT;
                  busy    <= 1'b1;
                  state   <= ST_FETCH;
               end
            end

            // ROM latency timer: load MIR when the down-counter reaches zero
            ST_FETCH: begin
               if (lat_cnt == 3'd0) begin
                  mir        <= mir_in;
                  alu_select <= mir_in[ALU_LSB +: ALU_W];
                  b_select   <= mir_in[B_LSB +: B_W];
                  state      <= ST_EXEC;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end

            ST_EXEC: begin
               alu_select <= mir_alu;
               b_select   <= mir_b;
               c_enable   <= mir_c;
               state      <= ST_WB;
            end

            ST_WB: begin
               nff        <= n_in;
               zff        <= z_in;
               alu_select <= '0;
               b_select   <= '0;
               c_enable   <= '0;
               if (mir_mem != 3'b000) begin
                  {mem_write, mem_read, mem_fetch} <= mir_mem;
                  state <= ST_MEMWAIT;
               end else begin
                  state <= ST_NEXT;
               end
            end

            ST_MEMWAIT: begin
               if (mem_ready) begin
                  {mem_write, mem_read, mem_fetch} <= 3'b000;
                  state <= ST_NEXT;
               end
            end

            // halt beats run=0, which beats a pending step
            ST_NEXT: begin
               if (next_mpc == HALT_ADDR) begin
                  mpc    <= next_mpc;
                  halted <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_HALT;
               end else if (!run) begin
                  mpc   <= next_mpc;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (step_ok) begin
                  mpc     <= next_mpc;
                  lat_cnt <= LAT_INIT;
                  state   <= ST_FETCH;
               end
            end

            ST_HALT: begin
               mpc <= HALT_ADDR;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mic1_sequencer.sv
// Self-checking bench for mic1_sequencer: directed and random microinstructions
// checked cycle by cycle against a phase-level model of the sequencer.
module tb_mic1_sequencer;

   localparam int         LAT   = 1;
   localparam int         LAT2  = 3;
   localparam logic [8:0] RST2  = 9'h023;
   localparam logic [7:0] T_ALU_A     = 8'h18;
   localparam logic [7:0] T_ALU_B     = 8'h14;
   localparam logic [7:0] T_ALU_NOT_A = 8'h1A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, run, run2, step, n_in, z_in, mem_ready;
   logic [35:0] mir_in, mir_in2;
   logic [7:0]  mbr;
   logic [8:0]  mpc, c_enable, mpc2, c2;
   logic [7:0]  alu_select, alu2;
   logic [3:0]  b_select, b2;
   logic        mem_write, mem_read, mem_fetch, halted, busy;
   logic        mw2, mr2, mf2, halted2, busy2;

   int          checks = 0;
   int          errors = 0;
   logic [8:0]  exp_mpc;
   bit          in_idle;

   mic1_sequencer #(.ROM_LATENCY(LAT), .RESET_MPC(9'h000)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
`ifdef MIC1_SEQ_STEP_EN
      .step(step),
`endif
      .mpc(mpc), .mir_in(mir_in), .alu_select(alu_select), .n_in(n_in), .z_in(z_in),
      .b_select(b_select), .c_enable(c_enable), .mem_write(mem_write), .mem_read(mem_read),
      .mem_fetch(mem_fetch), .mem_ready(mem_ready), .mbr(mbr), .halted(halted), .busy(busy)
   );

   mic1_sequencer #(.ROM_LATENCY(LAT2), .RESET_MPC(RST2)) dut2 (
      .clk(clk), .rst_n(rst_n), .run(run2),
`ifdef MIC1_SEQ_STEP_EN
      .step(step),
`endif
      .mpc(mpc2), .mir_in(mir_in2), .alu_select(alu2), .n_in(n_in), .z_in(z_in),
      .b_select(b2), .c_enable(c2), .mem_write(mw2), .mem_read(mr2),
      .mem_fetch(mf2), .mem_ready(mem_ready), .mbr(mbr), .halted(halted2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] outs1();
      return {alu_select, b_select, c_enable, mem_write, mem_read, mem_fetch};
   endfunction

   function automatic logic [35:0] mk(input logic [8:0] na, input logic jmpc, input logic jamn,
                                      input logic jamz, input logic [7:0] alu, input logic [8:0] c,
                                      input logic [2:0] mem, input logic [3:0] b);
      return {na, jmpc, jamn, jamz, alu, c, mem, b};
   endfunction

   // address rule: N/Z jams set bit 8, JMPC ORs MBR into the low byte
   function automatic logic [8:0] ref_next(input logic [35:0] w, input logic nv, input logic zv,
                                           input logic [7:0] mb);
      int a;
      a = int'(w[35:27]);
      if ((w[25] && nv) || (w[24] && zv)) a = a | 256;
      if (w[26]) a = a | int'(mb);
      return 9'(a);
   endfunction

   // Walks one microinstruction from its first FETCH cycle through NEXT.
   task automatic do_uinstr(input logic [35:0] w, input logic nv, input logic zv, input int dly,
                            input logic [7:0] mb, input logic run_nx);
      logic [8:0] nxt;
      if (in_idle) begin
         run = 1'b1;
         @(negedge clk);
         in_idle = 1'b0;
      end
      for (int i = 0; i < LAT; i++) begin
         mir_in = (i == LAT - 1) ? w : ~w;
         chk("fetch_mpc", 64'(mpc), 64'(exp_mpc));
         chk("fetch_busy", 64'(busy), 64'(1));
         chk("fetch_outs", 64'(outs1()), 64'(0));
         @(negedge clk);
      end
      mir_in = ~w;
      chk("exec_alu", 64'(alu_select), 64'(w[23:16]));
      chk("exec_b", 64'(b_select), 64'(w[3:0]));
      chk("exec_c_mem", 64'({c_enable, mem_write, mem_read, mem_fetch}), 64'(0));
      n_in = ~nv;
      z_in = ~zv;
      @(negedge clk);
      chk("wb_c", 64'(c_enable), 64'(w[15:7]));
      chk("wb_alu_b", 64'({alu_select, b_select}), 64'({w[23:16], w[3:0]}));
      chk("wb_mem", 64'({mem_write, mem_read, mem_fetch}), 64'(0));
      n_in = nv;
      z_in = zv;
      mem_ready = 1'b1;
      @(negedge clk);
      n_in = ~nv;
      z_in = ~zv;
      if (w[6:4] != 3'b000) begin
         for (int j = 0; j <= dly; j++) begin
            mem_ready = (j == dly);
            chk("mw_mem", 64'({mem_write, mem_read, mem_fetch}), 64'(w[6:4]));
            chk("mw_other", 64'({alu_select, b_select, c_enable}), 64'(0));
            chk("mw_busy", 64'(busy), 64'(1));
            @(negedge clk);
         end
      end
      mem_ready = 1'b0;
      chk("next_mpc_hold", 64'(mpc), 64'(exp_mpc));
      chk("next_outs", 64'(outs1()), 64'(0));
      chk("next_busy", 64'(busy), 64'(1));
      mbr = mb;
      run = run_nx;
      nxt = ref_next(w, nv, zv, mb);
      @(negedge clk);
      mbr = 8'($urandom);
      exp_mpc = nxt;
      chk("new_mpc", 64'(mpc), 64'(exp_mpc));
      if (nxt == 9'h1FF) begin
         chk("halt_flags", 64'({halted, busy}), 64'(2'b10));
      end else if (!run_nx) begin
         chk("idle_flags", 64'({halted, busy}), 64'(2'b00));
         in_idle = 1'b1;
      end else begin
         chk("refetch_flags", 64'({halted, busy}), 64'(2'b01));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n = 1'b0; run = 1'b0; run2 = 1'b0; step = 1'b1;
      n_in = 1'b0; z_in = 1'b0; mem_ready = 1'b0; mbr = 8'h00;
      mir_in = '0; mir_in2 = '0;
      exp_mpc = 9'h000; in_idle = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mpc", 64'(mpc), 64'(9'h000));
      chk("rst_outs", 64'(outs1()), 64'(0));
      chk("rst_flags", 64'({halted, busy}), 64'(0));
      chk("rst_mpc2", 64'(mpc2), 64'(RST2));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_hold", 64'({mpc, busy}), 64'({9'h000, 1'b0}));

      do_uinstr(mk(9'h005, 0, 0, 0, T_ALU_A, 9'h001, 3'b000, 4'h0), 0, 0, 0, 8'h00, 1);
      do_uinstr(mk(9'h010, 0, 0, 1, T_ALU_B, 9'h002, 3'b000, 4'h3), 0, 1, 0, 8'h00, 1);
      do_uinstr(mk(9'h010, 0, 0, 1, T_ALU_NOT_A, 9'h004, 3'b000, 4'h1), 1, 0, 0, 8'h00, 1);
      do_uinstr(mk(9'h000, 1, 0, 0, T_ALU_A, 9'h000, 3'b000, 4'h0), 0, 0, 0, 8'h59, 1);
      do_uinstr(mk(9'h021, 0, 0, 0, T_ALU_B, 9'h080, 3'b010, 4'h2), 0, 0, 3, 8'h00, 1);
      do_uinstr(mk(9'h030, 0, 1, 1, T_ALU_A, 9'h003, 3'b000, 4'h0), 1, 0, 0, 8'h00, 1);
      do_uinstr(mk(9'h031, 0, 1, 1, T_ALU_A, 9'h003, 3'b000, 4'h0), 0, 1, 0, 8'h00, 1);
      do_uinstr(mk(9'h042, 0, 0, 0, T_ALU_A, 9'h100, 3'b101, 4'h7), 0, 0, 0, 8'h00, 0);
      do_uinstr(mk(9'h043, 0, 1, 0, T_ALU_B, 9'h011, 3'b000, 4'h5), 1, 1, 0, 8'h00, 1);

      for (int k = 0; k < 40; k++) begin
         logic [35:0] w;
         logic        nv, zv, rn;
         logic [7:0]  mb;
         int          d;
         w  = mk(9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                 9'($urandom), ($urandom_range(0, 1) != 0) ? 3'($urandom) : 3'b000, 4'($urandom));
         nv = 1'($urandom);
         zv = 1'($urandom);
         mb = 8'($urandom);
         d  = $urandom_range(0, 4);
         rn = ($urandom_range(0, 3) != 0);
         if (ref_next(w, nv, zv, mb) == 9'h1FF) begin
            w[26] = 1'b0;
            w[27] = 1'b0;
         end
         do_uinstr(w, nv, zv, d, mb, rn);
      end

      do_uinstr(mk(9'h100, 1, 0, 0, T_ALU_A, 9'h001, 3'b000, 4'h0), 0, 0, 0, 8'hFF, 1);
      for (int i = 0; i < 3; i++) begin
         run = 1'(i);
         @(negedge clk);
         chk("halt_mpc", 64'(mpc), 64'(9'h1FF));
         chk("halt_flags_hold", 64'({halted, busy}), 64'(2'b10));
         chk("halt_outs", 64'(outs1()), 64'(0));
      end

      run = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_mpc", 64'(mpc), 64'(9'h000));
      chk("rst2_flags", 64'({halted, busy}), 64'(0));
      rst_n = 1'b1;
      exp_mpc = 9'h000;
      in_idle = 1'b1;

      // long-latency instance: garbage on mir_in2 until the final FETCH cycle
      run2 = 1'b1;
      @(negedge clk);
      for (int c = 0; c < LAT2 + 3; c++) begin
         run2 = 1'b0;
         mir_in2 = (c == LAT2 - 1) ? mk(9'h00A, 0, 0, 0, T_ALU_B, 9'h004, 3'b000, 4'h6)
                                   : ~mk(9'h00A, 0, 0, 0, T_ALU_B, 9'h004, 3'b000, 4'h6);
         chk("l3_mpc", 64'(mpc2), 64'(RST2));
         chk("l3_busy", 64'(busy2), 64'(1));
         chk("l3_alu", 64'(alu2), 64'((c == LAT2 || c == LAT2 + 1) ? T_ALU_B : 8'h00));
         chk("l3_b", 64'(b2), 64'((c == LAT2 || c == LAT2 + 1) ? 4'h6 : 4'h0));
         chk("l3_c", 64'(c2), 64'((c == LAT2 + 1) ? 9'h004 : 9'h000));
         chk("l3_mem", 64'({mw2, mr2, mf2}), 64'(0));
         @(negedge clk);
      end
      chk("l3_idle", 64'({mpc2, busy2, halted2}), 64'({9'h00A, 2'b00}));
      @(negedge clk);
      chk("l3_idle_hold", 64'({mpc2, busy2}), 64'({9'h00A, 1'b0}));

      run = 1'b1;
      @(negedge clk);
      mir_in = mk(9'h055, 0, 0, 0, T_ALU_A, 9'h0FF, 3'b010, 4'h0);
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      chk("mw_read_before_rst", 64'(mem_read), 64'(1));
      run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_mem", 64'({mem_write, mem_read, mem_fetch}), 64'(0));
      chk("async_rst_mpc", 64'(mpc), 64'(9'h000));
      chk("async_rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run = 1'b1;
      @(negedge clk);
      mir_in = mk(9'h056, 0, 0, 0, T_ALU_A, 9'h1FE, 3'b000, 4'h0);
      repeat (2) @(negedge clk);
      chk("wb_c_before_rst", 64'(c_enable), 64'(9'h1FE));
      run = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_c", 64'(c_enable), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 64'({mpc, busy, outs1()}), 64'(0));

`ifdef MIC1_SEQ_STEP_EN
      step = 1'b0;
      run = 1'b1;
      @(negedge clk);
      mir_in = mk(9'h033, 0, 0, 0, T_ALU_A, 9'h001, 3'b000, 4'h0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("step_wait_mpc", 64'({mpc, busy}), 64'({9'h000, 1'b1}));
         chk("step_wait_outs", 64'(outs1()), 64'(0));
         @(negedge clk);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("step_one_mpc", 64'(mpc), 64'(9'h033));
      mir_in = mk(9'h044, 0, 0, 0, T_ALU_B, 9'h002, 3'b000, 4'h0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("step_wait2_mpc", 64'({mpc, busy}), 64'({9'h033, 1'b1}));
         @(negedge clk);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
